// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a tie goes to the port that did not win last.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    if (&req) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = PORT_DMA;
    end else begin
      grant = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU port (0) and the debug/DMA port (1),
// one access at a time, with a registered ack/err/rdata return per port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          MEMREAD,
  output logic          MEMWRITE,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic pick_valid;
  logic pick_grant;
  logic in_range;

  rr_pick2 u_pick (
    .req       ({req1, req0}),
    .last_grant(last_grant_q),
    .valid     (pick_valid),
    .grant     (pick_grant)
  );

  // The latched address is the memory address, so the range check needs no extra flop.
  always_comb begin
    in_range = (mem_addr_q < AW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DMA;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    if ((state_q == IDLE) && pick_valid) begin
      last_grant_d = pick_grant;
      port_d       = pick_grant;
      we_d         = (pick_grant == PORT_DMA) ? we1    : we0;
      mem_addr_d   = (pick_grant == PORT_DMA) ? addr1  : addr0;
      mem_wdata_d  = (pick_grant == PORT_DMA) ? wdata1 : wdata0;
    end

    // Completion is registered at the end of ACCESS so ack/err/rdata appear together in DONE.
    if (state_q == ACCESS) begin
      if (port_q == PORT_DMA) begin
        ack1_d = 1'b1;
        err1_d = ~in_range;
        if (!we_q) rdata1_d = in_range ? mem_rdata : '0;
      end else begin
        ack0_d = 1'b1;
        err0_d = ~in_range;
        if (!we_q) rdata0_d = in_range ? mem_rdata : '0;
      end
    end
  end

  // Strobes are gated by reset so an aborted access releases the memory immediately.
  always_comb begin
    MEMREAD   = (state_q == ACCESS) && in_range && !we_q && !reset;
    MEMWRITE  = (state_q == ACCESS) && in_range &&  we_q && !reset;
    busy      = (state_q != IDLE);
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    ack0      = ack0_q;
    ack1      = ack1_q;
    err0      = err0_q;
    err1      = err1_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 32-word data memory.
module tb_dmem_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          MEMREAD, MEMWRITE, busy;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'(i * 100);
      mem[10]  <= 64'd1540;
      mem[11]  <= 64'd2117;
      mem_init <= 1'b1;
    end else if (MEMWRITE && mem_addr < 64'(DEPTH)) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = (MEMREAD && mem_addr < 64'(DEPTH)) ? mem[mem_addr[4:0]]
                                                         : 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic          we;
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          q0[$], q1[$];
  int            order_q[$], ackcyc_q[$];
  logic [DW-1:0] held0 = '0, held1 = '0;
  int            cyc = 0, rd_cnt = 0, wr_cnt = 0;
  int            n_checks = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int p);
    exp_t          e;
    logic [DW-1:0] exp_rd;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack%0d: got ack=1 required ack=0", p);
      return;
    end
    if (p == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    exp_rd = e.we ? ((p == 0) ? held0 : held1) : e.rd;
    check($sformatf("err%0d", p), (p == 0) ? 64'(err0) : 64'(err1), 64'(e.err));
    check($sformatf("rdata%0d", p), (p == 0) ? rdata0 : rdata1, exp_rd);
    if (p == 0) held0 = exp_rd;
    else        held1 = exp_rd;
    order_q.push_back(p);
    ackcyc_q.push_back(cyc);
  endtask

  // Monitor: scoreboard pops on every ack, plus strobe safety checks.
  always @(negedge clk) begin
    if (MEMREAD)  rd_cnt++;
    if (MEMWRITE) wr_cnt++;
    if (MEMREAD || MEMWRITE) begin
      check("strobe_exclusive", 64'(MEMREAD & MEMWRITE), 64'd0);
      check("strobe_busy", 64'(busy), 64'd1);
    end
    if (reset) begin
      held0 = '0;
      held1 = '0;
    end else begin
      if (ack0 && ack1) check("single_ack", 64'(ack0 & ack1), 64'd0);
      if (ack0) sb_pop(0);
      if (ack1) sb_pop(1);
    end
  end

  task automatic access(input int p, input logic we, input logic [63:0] addr,
                        input logic [63:0] wd, input logic exp_err,
                        input logic [63:0] exp_rd, output int lat);
    exp_t e;
    bit   got;
    int   t0;
    e.we = we; e.err = exp_err; e.rd = exp_rd;
    @(negedge clk);
    if (p == 0) begin
      q0.push_back(e); req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      q1.push_back(e); req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end
    t0  = cyc;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout port %0d: got no ack required ack within 40 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_acks"},  {62'd0, ack0, ack1}, 64'd0);
    check({tag, "_errs"},  {62'd0, err0, err1}, 64'd0);
    check({tag, "_rdata0"}, rdata0, 64'd0);
    check({tag, "_rdata1"}, rdata1, 64'd0);
    check({tag, "_strobes"}, {62'd0, MEMREAD, MEMWRITE}, 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    order_q.delete();
    ackcyc_q.delete();
  endtask

  initial begin
    int lat, lat_a, lat_b, rd0, wr0, bad;
    logic [DW-1:0] img;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Single read from port 0
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(0, 1'b0, 64'd10, 64'd0, 1'b0, 64'd1540, lat);
    check("read10_latency", 64'(lat), 64'd2);
    check("read10_memread_cycles", 64'(rd_cnt - rd0), 64'd1);
    check("read10_memwrite_cycles", 64'(wr_cnt - wr0), 64'd0);

    // Port 1 write then read back, port 0 sees the new value
    access(1, 1'b1, 64'd5, 64'hABCD, 1'b0, 64'd0, lat);
    check("write5_mem", mem[5], 64'hABCD);
    access(1, 1'b0, 64'd5, 64'd0, 1'b0, 64'hABCD, lat);
    access(0, 1'b0, 64'd5, 64'd0, 1'b0, 64'hABCD, lat);

    // Simultaneous requests after reset: port 0 first, port 1 three cycles later
    do_reset();
    fork
      access(0, 1'b0, 64'd3, 64'd0, 1'b0, 64'd300, lat_a);
      access(1, 1'b0, 64'd4, 64'd0, 1'b0, 64'd400, lat_b);
    join
    check("tie_ack_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) begin
      check("tie_first_port", 64'(order_q[0]), 64'd0);
      check("tie_second_port", 64'(order_q[1]), 64'd1);
      check("tie_ack_spacing", 64'(ackcyc_q[1] - ackcyc_q[0]), 64'd3);
    end

    // Continuous back-to-back reads from both ports
    order_q.delete();
    ackcyc_q.delete();
    fork
      for (int i = 1; i <= 4; i++) access(0, 1'b0, 64'(i), 64'd0, 1'b0, 64'(i * 100), lat_a);
      for (int i = 20; i <= 23; i++) access(1, 1'b0, 64'(i), 64'd0, 1'b0, 64'(i * 100), lat_b);
    join
    check("rr_ack_count", 64'(order_q.size()), 64'd8);
    for (int i = 0; i < order_q.size(); i++) begin
      check($sformatf("rr_port_%0d", i), 64'(order_q[i]), 64'(i % 2));
      if (i > 0) check($sformatf("rr_spacing_%0d", i), 64'(ackcyc_q[i] - ackcyc_q[i-1]), 64'd3);
    end

    // Out-of-range accesses: error flagged, no strobes, memory untouched
    rd0 = rd_cnt; wr0 = wr_cnt;
    access(0, 1'b0, 64'd32, 64'd0, 1'b1, 64'd0, lat);
    access(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 64'd0, lat);
    check("oor_memread_cycles", 64'(rd_cnt - rd0), 64'd0);
    check("oor_memwrite_cycles", 64'(wr_cnt - wr0), 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      img = 64'(i * 100);
      if (i == 10) img = 64'd1540;
      if (i == 11) img = 64'd2117;
      if (i == 5)  img = 64'hABCD;
      if (mem[i] !== img) bad++;
    end
    check("oor_mem_unchanged", 64'(bad), 64'd0);

    // Reset during ACCESS of a port 1 read aborts it without an ack
    order_q.delete();
    ackcyc_q.delete();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'd7;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req1  = 1'b0;
    @(negedge clk);
    check("abort_strobes_in_reset", {62'd0, MEMREAD, MEMWRITE}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (6) @(negedge clk);
    check("abort_no_ack", 64'(order_q.size()), 64'd0);
    fork
      access(0, 1'b0, 64'd6, 64'd0, 1'b0, 64'd600, lat_a);
      access(1, 1'b0, 64'd8, 64'd0, 1'b0, 64'd800, lat_b);
    join
    check("abort_tie_count", 64'(order_q.size()), 64'd2);
    if (order_q.size() == 2) check("abort_tie_first", 64'(order_q[0]), 64'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single data memory (addr/idata/MEMREAD/MEMWRITE/odata interface) between port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- Grants one access at a time using round-robin priority.
- Drives the memory control strobes for exactly one cycle per access and returns read data through a registered ack/rdata handshake.
- Sits between the requesters and the data memory. It is the only driver of the memory's control inputs.

Parameters:
- AW, 64, address width of the requester and memory ports.
- DW, 64, data width.
- DEPTH, 32, number of memory words. Any address >= DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request from port 0 / port 1. Held high until ack.
- we0 / we1  in  1  1 = write, 0 = read. Stable while req is high.
- addr0 / addr1  in  AW  word address. Stable while req is high.
- wdata0 / wdata1  in  DW  write data. Stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  out-of-range flag, valid with ack.
- rdata0 / rdata1  out  DW  read data, valid with ack. Held until the next ack on the same port.
- mem_addr  out  AW  drives the memory addr input.
- mem_wdata  out  DW  drives the memory idata input.
- MEMREAD  out  1  memory read strobe.
- MEMWRITE  out  1  memory write strobe.
- mem_rdata  in  DW  memory odata.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs = 0: ack, err, rdata, MEMREAD, MEMWRITE, mem_addr, mem_wdata, busy.
  - last_grant = 1, so port 0 wins the first tie.
- Reset mid-transaction:
  - Aborts the transaction with no ack.
  - Strobes drop in the reset cycle. A write in progress may or may not have landed.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On the grant edge: latch the winner's we/addr/wdata into internal registers, set last_grant, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - In range: MEMWRITE = we, MEMREAD = ~we.
  - Out of range: both strobes stay 0 and no memory access occurs.
  - At the end of the cycle, capture mem_rdata into the granted port's rdata. Reads only; rdata is unchanged on writes. On an out-of-range read, rdata = 0.
  - Then go to DONE.
- DONE (1 cycle):
  - Granted port's ack = 1. err = 1 if the address was out of range.
  - Then go to IDLE.
- Latency and throughput:
  - req sampled high at IDLE edge N -> ack high during cycle N+2.
  - One access per 3 cycles at most.
- Handshake:
  - The requester must drop req (or present a new request) at the edge ending its ack cycle.
  - req high in IDLE is always treated as a new request.
- If req drops during ACCESS or DONE, the latched transaction still completes and is acked.
- Memory-safety rules:
  - MEMWRITE and MEMREAD are never both high.
  - Both strobes are 0 outside ACCESS.
  - mem_addr and mem_wdata change only at the IDLE->ACCESS edge and hold afterwards, so no write glitches occur while MEMWRITE is high.
- Range check: compare the full AW bits, unsigned, against DEPTH.
- The non-granted port's ack, err and rdata are unaffected by the other port's transaction.

Decomposition:
- Shared package dmem_arb_pkg:
  - State enum {IDLE, ACCESS, DONE}.
  - Port index constants PORT_CPU = 0, PORT_DMA = 1.
  - Default DEPTH constant.
- One natural sub-module, rr_pick2: combinational 2-way round-robin pick. Inputs req[1:0] and last_grant; outputs valid and grant.
- FSM, latches and the range check stay in the top.

Test Plan (memory preloaded with Data[i] = i*100, Data[10] = 1540, Data[11] = 2117):
- Port 0 reads addr 10 -> ack0 at N+2, rdata0 = 1540, err0 = 0, MEMREAD high exactly 1 cycle, MEMWRITE never high.
- Port 1 writes addr 5 = 0xABCD, then reads addr 5 -> ack1 twice, rdata1 = 0xABCD. Port 0 reads addr 5 -> 0xABCD.
- After reset, req0 and req1 rise together with port 0 addr 3 and port 1 addr 4 -> port 0 is served first (rdata0 = 300), then port 1 (rdata1 = 400). ack1 arrives exactly 3 cycles after ack0.
- Both ports hold continuous back-to-back reads -> grants alternate 0,1,0,1. No port is starved and there is 1 ack per 3 cycles.
- Port 0 reads addr 32, then writes addr 0xFFFF_FFFF_FFFF_FFFF -> ack0 with err0 = 1 both times, rdata0 = 0, both strobes stay 0, and Data[] is unchanged.
- reset asserted during ACCESS of a port 1 read -> no ack1, all outputs 0 in the following cycle, busy = 0. A subsequent tie is granted to port 0.
